// File: rtl/vending_pkg.sv
// Shared types for the vending machine: change-dispenser FSM states, coin values, item codes.
// The ST_ERR state only exists when CHG_TIMEOUT_EN is defined.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
`ifdef CHG_TIMEOUT_EN
    , ST_ERR
`endif
  } chg_state_t;

  typedef enum logic {
    SEL_FIVE,
    SEL_TEN
  } coin_sel_t;

  localparam int COIN_TEN  = 10;
  localparam int COIN_FIVE = 5;

  // One-hot item codes, shared with the VendingMachine front end.
  typedef enum logic [3:0] {
    ITEM_NONE  = 4'b0000,
    ITEM_WATER = 4'b0001,
    ITEM_SODA  = 4'b0010,
    ITEM_CHIPS = 4'b0100,
    ITEM_CANDY = 4'b1000
  } item_t;

  function automatic int coin_value(input coin_sel_t sel);
    return (sel == SEL_TEN) ? COIN_TEN : COIN_FIVE;
  endfunction

endpackage

// File: rtl/coin_counter.sv
// Saturating up/down inventory counter for one coin denomination.
// Simultaneous inc and dec cancel; the count never wraps past 0 or all-ones.
module coin_counter #(
  parameter int CNT_W = 8,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= CNT_W'(INIT);
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as 10/5-rupee coins, greedy largest-first, via hopper eject/ack.
// Optional hopper-ack timeout with sticky error state: define CHG_TIMEOUT_EN.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 8,
  parameter int TEN_INIT    = 16,
  parameter int FIVE_INIT   = 32,
  parameter int GAP_CYC     = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  output logic             eject_ten,
  output logic             eject_five,
  input  logic             hopper_ack,
  input  logic             refill_ten,
  input  logic             refill_five,
  output logic [CNT_W-1:0] ten_cnt,
  output logic [CNT_W-1:0] five_cnt,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic             err_timeout
);

  localparam logic [AMT_W-1:0] TEN_V    = AMT_W'(COIN_TEN);
  localparam logic [AMT_W-1:0] FIVE_V   = AMT_W'(COIN_FIVE);
  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  chg_state_t       state, state_nx;
  coin_sel_t        coin;
  logic [AMT_W-1:0] rem;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept, pick_ten, pick_five, ack_take, gap_last, timeout;

  assign accept    = chg_valid && (state == ST_IDLE);
  assign pick_ten  = (rem >= TEN_V) && (ten_cnt != '0);
  assign pick_five = !pick_ten && (rem >= FIVE_V) && (five_cnt != '0);
  assign ack_take  = (state == ST_EJECT) && hopper_ack;
  assign gap_last  = (gap_cnt == GAP_LAST);

  coin_counter #(.CNT_W(CNT_W), .INIT(TEN_INIT)) u_ten_cnt (
    .clk (clk),
    .rst (rst),
    .inc (refill_ten),
    .dec (ack_take && coin == SEL_TEN),
    .cnt (ten_cnt)
  );

  coin_counter #(.CNT_W(CNT_W), .INIT(FIVE_INIT)) u_five_cnt (
    .clk (clk),
    .rst (rst),
    .inc (refill_five),
    .dec (ack_take && coin == SEL_FIVE),
    .cnt (five_cnt)
  );

`ifdef CHG_TIMEOUT_EN
  localparam int             TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign timeout     = (state == ST_EJECT) && !hopper_ack && (to_cnt == TO_LAST);
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == ST_EJECT) ? to_cnt + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  // ACK_TIMEOUT only matters in the timeout build; keep the parameter referenced.
  logic unused_ack_timeout;
  assign unused_ack_timeout = |ACK_TIMEOUT;
  assign timeout            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_SELECT;
      ST_SELECT: state_nx = (pick_ten || pick_five) ? ST_EJECT : ST_DONE;
      ST_EJECT: begin
        if (hopper_ack)   state_nx = ST_GAP;
        else if (timeout) state_nx = ST_DONE;
      end
      ST_GAP:    if (gap_last) state_nx = ST_SELECT;
`ifdef CHG_TIMEOUT_EN
      ST_DONE:   state_nx = err_q ? ST_ERR : ST_IDLE;
      ST_ERR:    state_nx = ST_ERR;
`else
      ST_DONE:   state_nx = ST_IDLE;
`endif
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem       <= '0;
      coin      <= SEL_FIVE;
      gap_cnt   <= '0;
      shortfall <= '0;
    end else begin
      if (accept) begin
        rem       <= chg_amt;
        shortfall <= '0;
      end
      if (state == ST_SELECT) begin
        coin <= pick_ten ? SEL_TEN : SEL_FIVE;
        if (!pick_ten && !pick_five) shortfall <= rem;
      end
      if (ack_take) rem <= rem - AMT_W'(coin_value(coin));
      if (timeout)  shortfall <= rem;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  assign chg_ready  = (state == ST_IDLE);
  assign eject_ten  = (state == ST_EJECT) && (coin == SEL_TEN);
  assign eject_five = (state == ST_EJECT) && (coin == SEL_FIVE);
  assign busy       = (state == ST_SELECT) || (state == ST_EJECT) ||
                      (state == ST_GAP)    || (state == ST_DONE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed hopper scenarios plus randomized
// amounts, ack delays and refills against a greedy coin-payout model.
module tb_change_dispenser;

  localparam int TEN_INIT  = 16;
  localparam int FIVE_INIT = 32;
  localparam int GAP_CYC   = 2;
  localparam int MAXC      = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       chg_valid, hopper_ack, refill_ten, refill_five;
  logic [7:0] chg_amt;
  logic       chg_ready, eject_ten, eject_five, busy, done, err_timeout;
  logic [7:0] ten_cnt, five_cnt, shortfall;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ten, m_five;

  change_dispenser dut (
    .clk         (clk),
    .rst         (rst),
    .chg_valid   (chg_valid),
    .chg_amt     (chg_amt),
    .chg_ready   (chg_ready),
    .eject_ten   (eject_ten),
    .eject_five  (eject_five),
    .hopper_ack  (hopper_ack),
    .refill_ten  (refill_ten),
    .refill_five (refill_five),
    .ten_cnt     (ten_cnt),
    .five_cnt    (five_cnt),
    .busy        (busy),
    .done        (done),
    .shortfall   (shortfall),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    m_ten  = TEN_INIT;
    m_five = FIVE_INIT;
  endtask

  task automatic check_counts(input string tag);
    n_cmp++;
    if (ten_cnt !== 8'(m_ten) || five_cnt !== 8'(m_five)) begin
      n_bad++;
      $display("FAIL %s counts: got ten=%0d five=%0d, expected ten=%0d five=%0d",
               tag, ten_cnt, five_cnt, m_ten, m_five);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (chg_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (chg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s wait_ready: chg_ready=%b, expected 1 within 200 cycles", tag, chg_ready);
    end
  endtask

  task automatic pulse_refill(input int n_ten, input int n_five);
    for (int i = 0; i < n_ten || i < n_five; i++) begin
      refill_ten  = (i < n_ten);
      refill_five = (i < n_five);
      tick();
    end
    refill_ten  = 1'b0;
    refill_five = 1'b0;
    m_ten  = (m_ten + n_ten > MAXC) ? MAXC : m_ten + n_ten;
    m_five = (m_five + n_five > MAXC) ? MAXC : m_five + n_five;
  endtask

  // Runs one full transaction; the model pays greedily from its own inventory.
  task automatic run_txn(input string tag, input int amt, input bit rand_ack);
    int  exp_q[$];
    int  exp_short, r, edges, got, d, drop_edge;
    bit  fin, first, no_coin;
    r = amt;
    forever begin
      if (r >= 10 && m_ten > 0)      begin exp_q.push_back(10); r -= 10; m_ten--;  end
      else if (r >= 5 && m_five > 0) begin exp_q.push_back(5);  r -= 5;  m_five--; end
      else break;
    end
    exp_short = r;
    no_coin   = (exp_q.size() == 0);

    wait_ready(tag);
    chg_valid = 1'b1;
    chg_amt   = 8'(amt);
    tick();
    chg_valid = 1'b0;
    edges = 1;
    n_cmp++;
    if (busy !== 1'b1 || chg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after_accept: busy=%b ready=%b, expected busy=1 ready=0", tag, busy, chg_ready);
    end
    fin = 0; first = 1; drop_edge = -100;
    while (!fin && edges < 2000) begin
      if (eject_ten === 1'b1 && eject_five === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL %s both_ejects: eject_ten=1 eject_five=1, expected at most one", tag);
        fin = 1;
      end else if (done === 1'b1) begin
        fin = 1;
        if (no_coin) begin
          n_cmp++;
          if (edges != 2) begin
            n_bad++;
            $display("FAIL %s done_latency: done after %0d cycles, expected 2", tag, edges);
          end
        end
        n_cmp++;
        if (shortfall !== 8'(exp_short) || exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL %s shortfall: got %0d (%0d coins unpaid), expected %0d (0 unpaid)",
                   tag, shortfall, exp_q.size(), exp_short);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || chg_ready !== 1'b1 || shortfall !== 8'(exp_short)) begin
          n_bad++;
          $display("FAIL %s post_done: done=%b busy=%b ready=%b shortfall=%0d, expected 0 0 1 %0d",
                   tag, done, busy, chg_ready, shortfall, exp_short);
        end
        check_counts(tag);
      end else if (eject_ten === 1'b1 || eject_five === 1'b1) begin
        got = eject_ten ? 10 : 5;
        if (first) begin
          n_cmp++;
          if (edges != 2) begin
            n_bad++;
            $display("FAIL %s eject_latency: first eject after %0d cycles, expected 2", tag, edges);
          end
          first = 0;
        end else begin
          n_cmp++;
          if (edges - drop_edge < GAP_CYC) begin
            n_bad++;
            $display("FAIL %s gap: %0d idle cycles, expected at least %0d", tag, edges - drop_edge, GAP_CYC);
          end
        end
        n_cmp++;
        if (exp_q.size() == 0 || exp_q[0] != got) begin
          n_bad++;
          $display("FAIL %s coin: got %0d, expected %0d", tag, got, (exp_q.size() == 0) ? 0 : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        d = rand_ack ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < d; i++) begin
          tick();
          edges++;
          n_cmp++;
          if ((got == 10 && eject_ten !== 1'b1) || (got == 5 && eject_five !== 1'b1)) begin
            n_bad++;
            $display("FAIL %s eject_hold: eject of %0d dropped before ack", tag, got);
          end
        end
        hopper_ack = 1'b1;
        tick();
        edges++;
        hopper_ack = 1'b0;
        drop_edge = edges;
        n_cmp++;
        if (eject_ten !== 1'b0 || eject_five !== 1'b0) begin
          n_bad++;
          $display("FAIL %s eject_drop: ten=%b five=%b after ack, expected 0 0", tag, eject_ten, eject_five);
        end
      end else begin
        tick();
        edges++;
      end
    end
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL %s no_done: done not seen within 2000 cycles", tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (chg_ready !== 1'b1 || eject_ten !== 1'b0 || eject_five !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || shortfall !== 8'd0 || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b ejects=%b%b busy=%b done=%b short=%0d err=%b, expected 1 00 0 0 0 0",
               chg_ready, eject_ten, eject_five, busy, done, shortfall, err_timeout);
    end
    check_counts("reset");
  endtask

  task automatic test_directed();
    run_txn("amt15", 15, 1'b0);
    run_txn("drain_ten", 150, 1'b1);
    run_txn("amt25_fives", 25, 1'b1);
    run_txn("drain_five", 130, 1'b0);
    pulse_refill(1, 1);
    check_counts("refill_1_1");
    run_txn("amt20_short", 20, 1'b1);
    pulse_refill(0, 3);
    run_txn("amt7", 7, 1'b0);
    run_txn("amt0", 0, 1'b0);
    run_txn("amt3", 3, 1'b0);
  endtask

  task automatic test_reset_mid_eject();
    int n = 0;
    do_reset();
    wait_ready("rst_mid");
    chg_valid = 1'b1;
    chg_amt   = 8'd10;
    tick();
    chg_valid = 1'b0;
    while (eject_ten !== 1'b1 && n < 10) begin tick(); n++; end
    rst        = 1'b0;
    hopper_ack = 1'b1;
    tick();
    hopper_ack = 1'b0;
    n_cmp++;
    if (eject_ten !== 1'b0 || eject_five !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_eject: ejects=%b%b busy=%b, expected 00 0", eject_ten, eject_five, busy);
    end
    check_counts("rst_mid_eject");
    rst = 1'b1;
    tick();
    n_cmp++;
    if (chg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release_ready: chg_ready=%b, expected 1", chg_ready);
    end
  endtask

  task automatic test_refill_ack_same();
    int n = 0;
    wait_ready("refill_ack");
    chg_valid = 1'b1;
    chg_amt   = 8'd5;
    tick();
    chg_valid = 1'b0;
    while (eject_five !== 1'b1 && n < 10) begin tick(); n++; end
    hopper_ack  = 1'b1;
    refill_five = 1'b1;
    tick();
    hopper_ack  = 1'b0;
    refill_five = 1'b0;
    check_counts("refill_ack_same");
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++;
    if (done !== 1'b1 || shortfall !== 8'd0) begin
      n_bad++;
      $display("FAIL refill_ack_done: done=%b shortfall=%0d, expected 1 0", done, shortfall);
    end
    tick();
  endtask

  task automatic test_random();
    int amt;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) pulse_refill($urandom_range(0, 3), $urandom_range(0, 4));
      amt = ($urandom_range(0, 1) == 0) ? 5 * $urandom_range(0, 40) : $urandom_range(0, 255);
      run_txn($sformatf("rand%0d", t), amt, 1'b1);
    end
  endtask

`ifdef CHG_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    int n = 0;
    do_reset();
    wait_ready("timeout");
    chg_valid = 1'b1;
    chg_amt   = 8'd20;
    tick();
    chg_valid = 1'b0;
    while (eject_ten !== 1'b1 && n < 10) begin tick(); n++; end
    while (eject_ten === 1'b1 && held < 200) begin tick(); held++; end
    n_cmp++;
    if (held != 64 || err_timeout !== 1'b1 || done !== 1'b1 || shortfall !== 8'd20) begin
      n_bad++;
      $display("FAIL timeout: held=%0d err=%b done=%b short=%0d, expected 64 1 1 20",
               held, err_timeout, done, shortfall);
    end
    m_ten = TEN_INIT;
    check_counts("timeout");
    repeat (5) tick();
    n_cmp++;
    if (chg_ready !== 1'b0 || err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL err_hold: ready=%b err=%b, expected 0 1", chg_ready, err_timeout);
    end
    do_reset();
    n_cmp++;
    if (chg_ready !== 1'b1 || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: ready=%b err=%b, expected 1 0", chg_ready, err_timeout);
    end
  endtask
`endif

  initial begin
    rst         = 1'b0;
    chg_valid   = 1'b0;
    chg_amt     = 8'd0;
    hopper_ack  = 1'b0;
    refill_ten  = 1'b0;
    refill_five = 1'b0;
    m_ten       = TEN_INIT;
    m_five      = FIVE_INIT;
    test_reset();
    test_directed();
    test_reset_mid_eject();
    test_refill_ack_same();
    test_random();
`ifdef CHG_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
